if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013: instruction injected as bubble.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-low reset.
REQ-005 load_stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 flush  input  1  taken branch/jump; redirect fetch and squash IF/ID.
REQ-007 br_target  input  32  redirect address, sampled when flush=1.
REQ-008 imem_addr  output  32  instruction memory address, equal to the current PC register.
REQ-009 imem_rdata  input  32  instruction word at imem_addr, combinational (same-cycle) read.
REQ-010 id_pc  output  32  PC of the instruction held in IF/ID.
REQ-011 id_inst  output  32  instruction held in IF/ID.
REQ-012 id_valid  output  1  IF/ID holds a real fetched instruction (0 = bubble).
REQ-013 stall_cnt  output  32  count of cycles in RUN with load_stall=1 and flush=0.
REQ-014 flush_cnt  output  32  count of cycles in RUN with flush=1.

Function
REQ-015 The FSM SHALL have states BOOT and RUN; reset enters BOOT; BOOT->RUN unconditionally after one clock; RUN has no exit other than reset.
REQ-016 In BOOT the PC SHALL hold RESET_PC, IF/ID SHALL load {RESET_PC, NOP_INST, valid=0}, and load_stall, flush and the counters SHALL be ignored.
REQ-017 In RUN the priority SHALL be flush > load_stall > normal advance.
REQ-018 Flush: PC <= br_target; IF/ID <= {pc=current PC, inst=NOP_INST, valid=0}; flush_cnt += 1.
REQ-019 Stall (flush=0): PC, id_pc, id_inst and id_valid SHALL hold their values; stall_cnt += 1.
REQ-020 Normal: PC <= PC + 4 (32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000); IF/ID <= {PC, imem_rdata, valid=1}.
REQ-021 Flush and load_stall both asserted SHALL behave exactly as flush alone; stall_cnt SHALL NOT increment.
REQ-022 Fetch-to-ID latency SHALL be one cycle: the word at imem_addr in cycle N appears on id_inst in cycle N+1 when cycle N is a normal advance.
REQ-023 br_target[1:0] SHALL be forced to 2'b00 when loaded into the PC.
REQ-024 Both counters SHALL wrap modulo 2^32 without affecting any other behaviour.
REQ-025 All outputs SHALL be driven directly from registers, except imem_addr, which equals the PC register.

Reset
REQ-026 On rstn=0, asynchronously: PC=RESET_PC, id_pc=RESET_PC, id_inst=NOP_INST, id_valid=0, stall_cnt=0, flush_cnt=0, state=BOOT.
REQ-027 Reset asserted mid-stall or mid-flush SHALL override both immediately; no pending redirect survives reset.
REQ-028 The first instruction fetched after reset release SHALL be at RESET_PC, and SHALL appear on id_inst two rising edges after rstn deasserts (one BOOT cycle, then one RUN advance).

Verification
REQ-029 Reset release, no stall/flush, imem returns addr^32'hA5A5_0000 -> id_pc sequence 0,4,8,12 with id_valid=1 from the second edge; counters stay 0.
REQ-030 load_stall=1 for 3 cycles while id_pc=8 -> id_pc=8 and id_inst held for 3 cycles, imem_addr=12 held, stall_cnt=3, then fetch resumes at 12.
REQ-031 flush=1 with br_target=32'h0000_0103 while PC=16 -> next cycle imem_addr=32'h0000_0100, id_inst=32'h0000_0013, id_valid=0, flush_cnt=1; the cycle after that id_pc=32'h100 with id_valid=1.
REQ-032 flush=1 and load_stall=1 in the same cycle -> redirect taken, bubble inserted, flush_cnt=1, stall_cnt=0.
REQ-033 PC preloaded via flush to br_target=32'hFFFF_FFFC, then one normal cycle -> imem_addr=32'h0000_0000, id_pc=32'hFFFF_FFFC.
REQ-034 rstn pulsed low during an active stall at PC=40 -> all outputs return to reset values asynchronously; the BOOT sequence of REQ-028 follows release.

Source files
------------

// File: rtl/if_id_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// A one-cycle BOOT state primes IF/ID with a bubble before fetching starts in RUN.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load_stall,
  input  logic        flush,
  input  logic [31:0] br_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  logic [31:0] pc_inc_d;
  logic [31:0] br_pc_d;

  // Redirect targets are word aligned; the 32-bit add wraps naturally.
  assign pc_inc_d = pc_q + 32'd4;
  assign br_pc_d  = {br_target[31:2], 2'b00};

  // NOTE: every register here uses non-blocking assignment so all state
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      id_pc_q     <= RESET_PC;
      id_inst_q   <= NOP_INST;
      id_valid_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        BOOT: begin
          state_q    <= RUN;
          pc_q       <= RESET_PC;
          id_pc_q    <= RESET_PC;
          id_inst_q  <= NOP_INST;
          id_valid_q <= 1'b0;
        end
        RUN: begin
          if (flush) begin
            pc_q        <= br_pc_d;
            id_pc_q     <= pc_q;
            id_inst_q   <= NOP_INST;
            id_valid_q  <= 1'b0;
            flush_cnt_q <= flush_cnt_q + 32'd1;
          end else if (load_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
          end else begin
            pc_q       <= pc_inc_d;
            id_pc_q    <= pc_q;
            id_inst_q  <= imem_rdata;
            id_valid_q <= 1'b1;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;
  assign id_valid  = id_valid_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage; imem returns addr ^ 32'hA5A5_0000.
// Each check compares {imem_addr, id_pc, id_inst, id_valid, stall_cnt, flush_cnt}.
module tb_if_id_stage;

  logic        clk;
  logic        rstn;
  logic        load_stall;
  logic        flush;
  logic [31:0] br_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int checks = 0;
  int errors = 0;

  typedef logic [160:0] snap_t;
  snap_t exp_s;

  if_id_stage dut (
    .clk        (clk),
    .rstn       (rstn),
    .load_stall (load_stall),
    .flush      (flush),
    .br_target  (br_target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
  );

  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t obs();
    return {imem_addr, id_pc, id_inst, id_valid, stall_cnt, flush_cnt};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; load_stall = 1'b0; flush = 1'b0; br_target = 32'h0;
    step();
    step();
    exp_s = {32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_boot_fetch();
    rstn = 1'b1;
    step();
    exp_s = {32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL boot_edge1 got %h exp %h", obs(), exp_s);
    end
    step();
    exp_s = {32'h4, 32'h0, 32'hA5A5_0000, 1'b1, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL boot_edge2 got %h exp %h", obs(), exp_s);
    end
    step();
    exp_s = {32'h8, 32'h4, 32'hA5A5_0004, 1'b1, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL fetch_pc4 got %h exp %h", obs(), exp_s);
    end
    step();
    exp_s = {32'hC, 32'h8, 32'hA5A5_0008, 1'b1, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL fetch_pc8 got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_stall();
    load_stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      exp_s = {32'hC, 32'h8, 32'hA5A5_0008, 1'b1, 32'(k), 32'd0};
      checks++;
      if (obs() !== exp_s) begin
        errors++; $display("FAIL stall_hold_%0d got %h exp %h", k, obs(), exp_s);
      end
    end
    load_stall = 1'b0;
    step();
    exp_s = {32'h10, 32'hC, 32'hA5A5_000C, 1'b1, 32'd3, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL stall_resume got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; br_target = 32'h0000_0103;
    step();
    exp_s = {32'h100, 32'h10, 32'h13, 1'b0, 32'd3, 32'd1};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL flush_bubble got %h exp %h", obs(), exp_s);
    end
    flush = 1'b0;
    step();
    exp_s = {32'h104, 32'h100, 32'hA5A5_0100, 1'b1, 32'd3, 32'd1};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL flush_target got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1; load_stall = 1'b1; br_target = 32'h0000_0200;
    step();
    exp_s = {32'h200, 32'h104, 32'h13, 1'b0, 32'd3, 32'd2};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL flush_and_stall got %h exp %h", obs(), exp_s);
    end
    load_stall = 1'b0;
  endtask

  task automatic test_wrap();
    flush = 1'b1; br_target = 32'hFFFF_FFFF;
    step();
    exp_s = {32'hFFFF_FFFC, 32'h200, 32'h13, 1'b0, 32'd3, 32'd3};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL wrap_preload got %h exp %h", obs(), exp_s);
    end
    flush = 1'b0;
    step();
    exp_s = {32'h0, 32'hFFFF_FFFC, 32'h5A5A_FFFC, 1'b1, 32'd3, 32'd3};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL wrap_advance got %h exp %h", obs(), exp_s);
    end
  endtask

  task automatic test_reset_mid_stall();
    flush = 1'b1; br_target = 32'h0000_0028;
    step();
    exp_s = {32'h28, 32'h0, 32'h13, 1'b0, 32'd3, 32'd4};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL jump_to_40 got %h exp %h", obs(), exp_s);
    end
    flush = 1'b0; load_stall = 1'b1;
    step();
    exp_s = {32'h28, 32'h0, 32'h13, 1'b0, 32'd4, 32'd4};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL stall_at_40 got %h exp %h", obs(), exp_s);
    end
    #2 rstn = 1'b0;
    #1;
    exp_s = {32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL async_reset got %h exp %h", obs(), exp_s);
    end
    // BOOT must ignore the still-asserted stall and flush.
    flush = 1'b1; br_target = 32'h0000_0300;
    step();
    rstn = 1'b1;
    step();
    exp_s = {32'h0, 32'h0, 32'h13, 1'b0, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL reboot_edge1 got %h exp %h", obs(), exp_s);
    end
    flush = 1'b0; load_stall = 1'b0;
    step();
    exp_s = {32'h4, 32'h0, 32'hA5A5_0000, 1'b1, 32'd0, 32'd0};
    checks++;
    if (obs() !== exp_s) begin
      errors++; $display("FAIL reboot_edge2 got %h exp %h", obs(), exp_s);
    end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_stall();
    test_flush();
    test_flush_stall();
    test_wrap();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
